// File: rtl/itch_pkg.sv
// Shared constants and types for the ITCH message dispatcher and its type decoder.
package itch_pkg;

  localparam int CNT_W_DEFAULT = 4;

  localparam logic [7:0] TYPE_ORDER_DELETE   = 8'h44;  // 'D'
  localparam logic [7:0] TYPE_ADD_ORDER      = 8'h41;  // 'A'
  localparam logic [7:0] TYPE_ORDER_EXECUTED = 8'h45;  // 'E'
  localparam logic [7:0] TYPE_ORDER_REPLACE  = 8'h55;  // 'U'
  localparam logic [7:0] TYPE_TIME_SECONDS   = 8'h54;  // 'T'

  localparam int START_W = 5;
  // Bit positions inside the one-hot start vector.
  localparam int BIT_DELETE   = 0;
  localparam int BIT_ADD      = 1;
  localparam int BIT_EXECUTED = 2;
  localparam int BIT_REPLACE  = 3;
  localparam int BIT_SECONDS  = 4;

  typedef logic [START_W-1:0] start_vec_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HEADER = 2'd1,
    ST_BODY   = 2'd2,
    ST_DRAIN  = 2'd3
  } state_e;

endpackage

// File: rtl/itch_type_decoder.sv
// Combinational decode of the ITCH message-type byte into a one-hot start vector.
module itch_type_decoder
  import itch_pkg::*;
(
  input  logic [7:0] type_byte_i,
  output start_vec_t start_vec_o,
  output logic       unknown_o
);

  // Byte-to-one-hot lookup; anything outside the five handled codes is unknown.
  always_comb begin
    start_vec_o = '0;
    unknown_o   = 1'b0;
    case (type_byte_i)
      TYPE_ORDER_DELETE:   start_vec_o[BIT_DELETE]   = 1'b1;
      TYPE_ADD_ORDER:      start_vec_o[BIT_ADD]      = 1'b1;
      TYPE_ORDER_EXECUTED: start_vec_o[BIT_EXECUTED] = 1'b1;
      TYPE_ORDER_REPLACE:  start_vec_o[BIT_REPLACE]  = 1'b1;
      TYPE_TIME_SECONDS:   start_vec_o[BIT_SECONDS]  = 1'b1;
      default:             unknown_o                 = 1'b1;
    endcase
  end

endmodule

// File: rtl/itch_msg_dispatcher.sv
// ITCH dispatcher: re-times beats, tracks beat index, raises per-type start flags.
// Optional ITCH_DISPATCH_STATS_EN adds msgCount/errCount statistics outputs.
module itch_msg_dispatcher
  import itch_pkg::*;
#(
  parameter int CNT_W     = CNT_W_DEFAULT,
  parameter int TYPE_BEAT = 8,
  parameter int TYPE_LANE = 0,
  parameter int MIN_BEATS = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [63:0]      dataIn,
  input  logic             dataValid,
  input  logic             sop,
  input  logic             eop,
  output logic [63:0]      dataOut,
  output logic             outValid,
  output logic [CNT_W-1:0] counter,
  output logic             startOrderDelete,
  output logic             startAddOrder,
  output logic             startOrderExecuted,
  output logic             startOrderReplace,
  output logic             startTimeSeconds,
  output logic             unknownType,
  output logic             truncated
`ifdef ITCH_DISPATCH_STATS_EN
  ,output logic [15:0]     msgCount
  ,output logic [15:0]     errCount
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] TYPE_IDX = CNT_W'(TYPE_BEAT);
  localparam logic [CNT_W-1:0] LAST_OK  = CNT_W'(MIN_BEATS - 1);

  state_e           state_q, state_d, eff_state_s;
  logic [63:0]      data_q;
  logic             valid_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  start_vec_t       flags_q, flags_d, dec_vec_s;
  logic             unk_q, unk_d, trunc_q, trunc_d, dec_unknown_s, in_pkt_s;

  itch_type_decoder u_dec (
    .type_byte_i (dataIn[8*TYPE_LANE +: 8]),
    .start_vec_o (dec_vec_s),
    .unknown_o   (dec_unknown_s)
  );

  // A sop always opens a header, even when it interrupts a packet in progress.
  assign eff_state_s = sop ? ST_HEADER : state_q;
  assign in_pkt_s    = sop || (state_q != ST_IDLE);

  // Next-state, beat index, flag and error-pulse computation.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    flags_d = flags_q;
    unk_d   = 1'b0;
    trunc_d = 1'b0;
    if (dataValid) begin
      cnt_d   = sop ? '0 : ((cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 1'b1);
      flags_d = '0;
      trunc_d = sop && (state_q != ST_IDLE);
      case (eff_state_s)
        ST_HEADER: begin
          if (cnt_d == TYPE_IDX) begin
            if (dec_unknown_s) begin
              unk_d   = 1'b1;
              state_d = ST_DRAIN;
            end else begin
              flags_d = dec_vec_s;
              state_d = ST_BODY;
            end
          end else begin
            state_d = ST_HEADER;
          end
        end
        ST_BODY:  flags_d = flags_q;
        ST_DRAIN: flags_d = '0;
        ST_IDLE:  flags_d = '0;
        default:  state_d = ST_IDLE;
      endcase
      if (in_pkt_s && eop) begin
        state_d = ST_IDLE;
        trunc_d = trunc_d || (cnt_d < LAST_OK);
      end else begin
        state_d = state_d;
      end
    end else if (state_q == ST_IDLE) begin
      // Flags clear the cycle after eop even if the line goes idle.
      flags_d = '0;
    end else begin
      flags_d = flags_q;
    end
  end

  // Output and state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      data_q  <= 64'd0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
      flags_q <= '0;
      unk_q   <= 1'b0;
      trunc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= dataIn;
      valid_q <= dataValid;
      cnt_q   <= cnt_d;
      flags_q <= flags_d;
      unk_q   <= unk_d;
      trunc_q <= trunc_d;
    end
  end

  assign dataOut            = data_q;
  assign outValid           = valid_q;
  assign counter            = cnt_q;
  assign startOrderDelete   = flags_q[BIT_DELETE];
  assign startAddOrder      = flags_q[BIT_ADD];
  assign startOrderExecuted = flags_q[BIT_EXECUTED];
  assign startOrderReplace  = flags_q[BIT_REPLACE];
  assign startTimeSeconds   = flags_q[BIT_SECONDS];
  assign unknownType        = unk_q;
  assign truncated          = trunc_q;

`ifdef ITCH_DISPATCH_STATS_EN
  logic [15:0] msg_q, err_q;
  logic        msg_inc_s;

  // A packet counts as delivered when its eop beat still carries a start flag.
  assign msg_inc_s = dataValid && in_pkt_s && eop && (flags_d != '0);

  // Statistics counters, wrapping modulo 2**16.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      msg_q <= 16'd0;
      err_q <= 16'd0;
    end else begin
      msg_q <= msg_q + {15'd0, msg_inc_s};
      err_q <= err_q + {15'd0, unk_d} + {15'd0, trunc_d};
    end
  end

  assign msgCount = msg_q;
  assign errCount = err_q;
`endif

endmodule

// File: tb/tb_itch_msg_dispatcher.sv
// Scoreboard bench for itch_msg_dispatcher: directed scenarios plus randomized packets.
module tb_itch_msg_dispatcher;

  localparam int TB_TYPE_BEAT = 8;
  localparam int TB_MIN_BEATS = 11;
  localparam int TB_CNT_MAX   = 15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] dataIn = 64'd0;
  logic        dataValid = 1'b0, sop = 1'b0, eop = 1'b0;
  logic [63:0] dataOut;
  logic        outValid;
  logic [3:0]  counter;
  logic        startOrderDelete, startAddOrder, startOrderExecuted;
  logic        startOrderReplace, startTimeSeconds, unknownType, truncated;
`ifdef ITCH_DISPATCH_STATS_EN
  logic [15:0] msgCount, errCount;
`endif

  itch_msg_dispatcher dut (
    .clk(clk), .rst_n(rst_n), .dataIn(dataIn), .dataValid(dataValid),
    .sop(sop), .eop(eop), .dataOut(dataOut), .outValid(outValid),
    .counter(counter), .startOrderDelete(startOrderDelete),
    .startAddOrder(startAddOrder), .startOrderExecuted(startOrderExecuted),
    .startOrderReplace(startOrderReplace), .startTimeSeconds(startTimeSeconds),
    .unknownType(unknownType), .truncated(truncated)
`ifdef ITCH_DISPATCH_STATS_EN
    , .msgCount(msgCount), .errCount(errCount)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ov;
    logic [63:0] d;
    logic [3:0]  cnt;
    logic [4:0]  fl;
    logic        unk;
    logic        trn;
    logic [15:0] mc;
    logic [15:0] ec;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Reference model: packet bookkeeping in terms of "inside a packet", "type already seen"
  // and the message kind currently announced.
  bit         m_in, m_typed;
  int         m_idx;
  logic [4:0] m_fl;
  int         m_mc, m_ec;
  logic [7:0] codes [5] = '{8'h44, 8'h41, 8'h45, 8'h55, 8'h54};

  function automatic logic [4:0] kind_of(input logic [7:0] b);
    logic [4:0] r = 5'd0;
    for (int k = 0; k < 5; k++) if (b == codes[k]) r[k] = 1'b1;
    return r;
  endfunction

  function automatic void model_reset();
    m_in = 0; m_typed = 0; m_idx = 0; m_fl = 5'd0; m_mc = 0; m_ec = 0;
  endfunction

  function automatic void model_step();
    exp_t x;
    bit   part;
    x.d = dataIn; x.ov = dataValid; x.unk = 1'b0; x.trn = 1'b0;
    if (!dataValid) begin
      if (!m_in) m_fl = 5'd0;
    end else begin
      m_idx = sop ? 0 : ((m_idx + 1 > TB_CNT_MAX) ? TB_CNT_MAX : m_idx + 1);
      part  = sop || m_in;
      if (sop && m_in) x.trn = 1'b1;
      if (sop) begin m_typed = 0; m_fl = 5'd0; end
      if (!part) m_fl = 5'd0;
      else begin
        if (!m_typed && m_idx == TB_TYPE_BEAT) begin
          m_typed = 1;
          m_fl    = kind_of(dataIn[7:0]);
          if (m_fl == 5'd0) x.unk = 1'b1;
        end
        if (eop) begin
          if (m_idx < TB_MIN_BEATS - 1) x.trn = 1'b1;
          if (m_fl != 5'd0) m_mc++;
          m_in = 0;
        end else m_in = 1;
      end
      m_ec += int'(x.unk) + int'(x.trn);
    end
    x.cnt = m_idx[3:0]; x.fl = m_fl; x.mc = m_mc[15:0]; x.ec = m_ec[15:0];
    exp_q.push_back(x);
  endfunction

  // Monitor: compare the registered outputs against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("outValid", {63'd0, outValid}, {63'd0, e.ov});
      if (e.ov) chk("dataOut", dataOut, e.d);
      chk("counter", {60'd0, counter}, {60'd0, e.cnt});
      chk("flags", {59'd0, startTimeSeconds, startOrderReplace, startOrderExecuted,
                    startAddOrder, startOrderDelete}, {59'd0, e.fl});
      chk("unknownType", {63'd0, unknownType}, {63'd0, e.unk});
      chk("truncated", {63'd0, truncated}, {63'd0, e.trn});
`ifdef ITCH_DISPATCH_STATS_EN
      chk("msgCount", {48'd0, msgCount}, {48'd0, e.mc});
      chk("errCount", {48'd0, errCount}, {48'd0, e.ec});
`endif
    end
  end

  task automatic beat(input bit v, input bit s, input bit e, input logic [63:0] d);
    dataValid = v; sop = s; eop = e; dataIn = d;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) beat(1'b0, 1'b0, 1'b0, {$urandom, $urandom});
  endtask

  // One packet; type byte goes to lane 0 of beat 8. Optional fixed gap and random gaps.
  task automatic send_pkt(input int len, input logic [7:0] t, input bit close,
                          input int gap_at, input int gap_len, input bit rnd_gaps);
    logic [63:0] d;
    for (int i = 0; i < len; i++) begin
      if (i == gap_at) idle(gap_len);
      if (rnd_gaps && i > 0 && $urandom_range(0, 5) == 0) idle($urandom_range(1, 3));
      d = {$urandom, $urandom};
      if (i == TB_TYPE_BEAT) d[7:0] = t;
      beat(1'b1, i == 0, close && (i == len - 1), d);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_outValid"}, {63'd0, outValid}, 64'd0);
    chk({tag, "_dataOut"}, dataOut, 64'd0);
    chk({tag, "_counter"}, {60'd0, counter}, 64'd0);
    chk({tag, "_flags"}, {59'd0, startTimeSeconds, startOrderReplace, startOrderExecuted,
                          startAddOrder, startOrderDelete}, 64'd0);
    chk({tag, "_errs"}, {62'd0, unknownType, truncated}, 64'd0);
`ifdef ITCH_DISPATCH_STATS_EN
    chk({tag, "_stats"}, {32'd0, msgCount, errCount}, 64'd0);
`endif
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check_all_zero("reset");
    model_reset();
    dataValid = 1'b0; sop = 1'b0; eop = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] t;
    int         r;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("por");
    rst_n = 1'b1;

    send_pkt(11, 8'h44, 1, -1, 0, 0); idle(2);   // Delete: flag for 8..10
    send_pkt(11, 8'h5A, 1, -1, 0, 0); idle(2);   // unknown type
    send_pkt(6, 8'h45, 1, -1, 0, 0);             // eop at 5 -> truncated
    send_pkt(11, 8'h54, 1, -1, 0, 0); idle(1);
    send_pkt(12, 8'h55, 1, 9, 3, 0); idle(1);    // 3 idle cycles mid-body
    send_pkt(10, 8'h41, 0, -1, 0, 0);            // interrupted at beat 9
    send_pkt(11, 8'h55, 1, -1, 0, 0);
    beat(1, 0, 0, 64'h1234); beat(1, 0, 1, 64'h5678); // stray beats in IDLE
    beat(1, 1, 1, 64'h44);                       // sop+eop one-beat packet
    send_pkt(20, 8'h41, 1, -1, 0, 0);            // index saturation
    send_pkt(9, 8'h44, 1, -1, 0, 0);             // truncated with flag on eop
    send_pkt(10, 8'h44, 0, -1, 0, 0);            // reset mid-packet
    do_reset();
    send_pkt(11, 8'h41, 1, -1, 0, 0);
    send_pkt(11, 8'h45, 1, -1, 0, 0);
    send_pkt(11, 8'h54, 1, -1, 0, 0);
    send_pkt(11, 8'h00, 1, -1, 0, 0);
    idle(2);

    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 6);
      t = (r < 5) ? codes[r] : 8'($urandom);
      if ($urandom_range(0, 9) == 0) beat(1, 0, $urandom_range(0, 1), {$urandom, $urandom});
      send_pkt($urandom_range(1, 20), t, $urandom_range(0, 7) != 0, -1, 0, 1);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end
    idle(3);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
